// File: rtl/shift_add_control.sv
// shift_add_control: control sequencer for an add-shift multiplier datapath.
// Runs one clear cycle followed by WIDTH add-then-shift iterations. The final
// iteration subtracts, because the multiplier's sign bit has negative weight.
// Optional feature macro: MULT_DONE_PULSE_EN adds a one-cycle Done pulse output
// that fires on the first cycle in DONE.
module shift_add_control #(
  parameter int WIDTH = 8
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Run,
  input  logic                         ClearA_LoadB,
  input  logic                         M,
  output logic                         Clr_Ld,
  output logic                         Clear_XA,
  output logic                         Ld_XA,
  output logic                         Fn,
  output logic                         Shift_En,
  output logic                         Busy,
  output logic [$clog2(WIDTH+1)-1:0]   Iter
`ifdef MULT_DONE_PULSE_EN
  ,
  output logic                         Done
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   iter_q,  iter_d;

  // State and iteration counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (Reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state logic and output decode; only Ld_XA and Clr_Ld look at inputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what would otherwise infer a latch.
    state_d  = state_q;
    iter_d   = iter_q;
    Clr_Ld   = 1'b0;
    Clear_XA = 1'b0;
    Ld_XA    = 1'b0;
    Fn       = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Run) begin
          state_d = CLR;
        end else if (ClearA_LoadB) begin
          Clr_Ld = 1'b1;
        end
      end
      CLR: begin
        Clear_XA = 1'b1;
        Busy     = 1'b1;
        iter_d   = '0;
        state_d  = ADD;
      end
      ADD: begin
        // Add only when the current multiplier bit is set; the last bit is
        // the sign bit and is applied with subtraction.
        Ld_XA   = M;
        Fn      = (iter_q == LAST_ITER);
        Busy    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        iter_d   = iter_q + CW'(1);
        state_d  = (iter_q == LAST_ITER) ? DONE : ADD;
      end
      DONE: begin
        // Hold here until the start button is released; no auto-restart.
        if (!Run) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Iter = iter_q;

`ifdef MULT_DONE_PULSE_EN
  logic done_q;

  // Done pulse: registered on the final shift so it is high only on DONE entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == SHIFT) && (iter_q == LAST_ITER);
    end
  end

  assign Done = done_q;
`endif

endmodule

// File: tb/tb_shift_add_control.sv
// tb_shift_add_control: directed-plus-random bench for shift_add_control.
// Expected outputs come from a cycle-index model of a multiply: cycle 0 of a
// run is the clear, then odd/even cycles alternate add and shift.
module tb_shift_add_control;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  localparam int VW = 6 + CW;

  logic          Clk = 1'b0;
  logic          Reset, Run, ClearA_LoadB, M;
  logic          Clr_Ld, Clear_XA, Ld_XA, Fn, Shift_En, Busy;
  logic [CW-1:0] Iter;
`ifdef MULT_DONE_PULSE_EN
  logic          Done;
`endif

  int checks = 0;
  int errors = 0;
  int model_iter = 0;

  shift_add_control #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .Clear_XA     (Clear_XA),
    .Ld_XA        (Ld_XA),
    .Fn           (Fn),
    .Shift_En     (Shift_En),
    .Busy         (Busy),
    .Iter         (Iter)
`ifdef MULT_DONE_PULSE_EN
    ,
    .Done         (Done)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [VW-1:0] pack(input logic clr_ld, input logic clear_xa,
                                         input logic ld, input logic fn,
                                         input logic sh, input logic busy,
                                         input int iter);
    return {clr_ld, clear_xa, ld, fn, sh, busy, CW'(iter)};
  endfunction

  function automatic logic [VW-1:0] observed();
    return {Clr_Ld, Clear_XA, Ld_XA, Fn, Shift_En, Busy, Iter};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_done(input string tag, input logic exp);
`ifdef MULT_DONE_PULSE_EN
    check(tag, 32'(Done), 32'(exp));
`endif
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  // One full multiply from IDLE. m_mode: 0 all zero, 1 all one, 2 random.
  // done_hold: cycles Run stays high in DONE before release.
  task automatic do_run(input int m_mode, input logic calb_start, input int done_hold);
    int ld_cnt, sh_cnt, busy_cnt, exp_ld;
    ld_cnt = 0; sh_cnt = 0; busy_cnt = 0; exp_ld = 0;

    Run = 1'b1; ClearA_LoadB = calb_start; M = 1'($urandom);
    @(negedge Clk);
    check("idle_start", 32'(observed()), 32'(pack(0, 0, 0, 0, 0, 0, model_iter)));
    check_done("idle_done", 1'b0);
    next();

    for (int j = 0; j <= 2 * W; j++) begin
      logic [VW-1:0] exp;
      Run          = 1'($urandom);
      ClearA_LoadB = 1'($urandom);
      M            = (m_mode == 2) ? 1'($urandom) : 1'(m_mode);
      if (j == 0) begin
        exp = pack(0, 1, 0, 0, 0, 1, model_iter);
      end else begin
        int i;
        i = (j - 1) / 2;
        if (((j - 1) % 2) == 0) begin
          exp = pack(0, 0, M, (i == W - 1), 0, 1, i);
          exp_ld += int'(M);
        end else begin
          exp = pack(0, 0, 0, 0, 1, 1, i);
        end
      end
      @(negedge Clk);
      check($sformatf("busy_cyc%0d", j), 32'(observed()), 32'(exp));
      check_done("busy_done", 1'b0);
      ld_cnt   += int'(Ld_XA);
      sh_cnt   += int'(Shift_En);
      busy_cnt += int'(Busy);
      if (j == 0) model_iter = 0;
      next();
    end
    model_iter = W;

    check("ld_count",    32'(ld_cnt),   32'(exp_ld));
    check("shift_count", 32'(sh_cnt),   32'(W));
    check("busy_count",  32'(busy_cnt), 32'(1 + 2 * W));

    for (int k = 0; k <= done_hold; k++) begin
      Run = (k < done_hold); ClearA_LoadB = 1'($urandom); M = 1'($urandom);
      @(negedge Clk);
      check("done_state", 32'(observed()), 32'(pack(0, 0, 0, 0, 0, 0, W)));
      check_done("done_pulse", (k == 0));
      next();
    end
    Run = 1'b0; ClearA_LoadB = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;

    // Reset held two cycles.
    next(); next();
    @(negedge Clk);
    check("reset_init", 32'(observed()), 32'(pack(0, 0, 0, 0, 0, 0, 0)));
    check_done("reset_done", 1'b0);
    next();
    Reset = 1'b0;

    // Clear/load request held three cycles in IDLE.
    for (int k = 0; k < 3; k++) begin
      ClearA_LoadB = 1'b1; M = 1'($urandom);
      @(negedge Clk);
      check("clr_ld_idle", 32'(observed()), 32'(pack(1, 0, 0, 0, 0, 0, 0)));
      next();
    end
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    check("idle_quiet", 32'(observed()), 32'(pack(0, 0, 0, 0, 0, 0, 0)));
    next();

    // Run and ClearA_LoadB together: Run wins. M=1 throughout.
    do_run(1, 1'b1, 0);
    // M=0 throughout, Run held in DONE for 10 cycles.
    do_run(0, 1'b0, 10);
    // Restart with random multiplier bits.
    do_run(2, 1'b0, 3);
    do_run(2, 1'b1, 1);

    // Clear/load after a run: Iter keeps its final value in IDLE.
    ClearA_LoadB = 1'b1;
    @(negedge Clk);
    check("clr_ld_after", 32'(observed()), 32'(pack(1, 0, 0, 0, 0, 0, W)));
    next();
    ClearA_LoadB = 1'b0;

    // Reset mid-run, in the ADD cycle with Iter=4.
    Run = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      next();
      M = 1'b1;
      Run = 1'($urandom);
    end
    Reset = 1'b1;
    @(negedge Clk);
    check("add_iter4", 32'(observed()), 32'(pack(0, 0, 1, 0, 0, 1, 4)));
    next();
    @(negedge Clk);
    check("reset_midrun", 32'(observed()), 32'(pack(0, 0, 0, 0, 0, 0, 0)));
    check_done("reset_mid_done", 1'b0);
    next();
    Reset = 1'b0; Run = 1'b0;
    model_iter = 0;
    @(negedge Clk);
    check("post_reset_idle", 32'(observed()), 32'(pack(0, 0, 0, 0, 0, 0, 0)));
    next();

    // Run to DONE, then reset from DONE.
    do_run(2, 1'b0, 5);
    Run = 1'b1;
    for (int j = 0; j < 2 * W + 2; j++) next();
    Reset = 1'b1;
    next(); next();
    @(negedge Clk);
    check("reset_from_done", 32'(observed()), 32'(pack(0, 0, 0, 0, 0, 0, 0)));
    next();
    Reset = 1'b0; Run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
